// File: rtl/updown_pkg.sv
// Shared types and constants for the parametrised up/down counter tile.
package updown_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_BOUNCE  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_gen_if.sv
// Control/status bundle between the decode logic (master) and the counter core (slave).
interface updown_counter_gen_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP_W     = 4,
  parameter int unsigned PRESCALE_W = 8
) ();

  logic                  en;
  logic                  dir;
  updown_pkg::mode_e     mode;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic [WIDTH-1:0]      limit;
  logic [STEP_W-1:0]     step;
  logic [PRESCALE_W-1:0] prescale;
  logic                  clr_flags;
  logic [WIDTH-1:0]      count;
  logic                  dir_eff;
  logic                  tc;
  logic                  ovf_sticky;
  logic                  at_max;
  logic                  at_min;
  logic                  running;

  modport master (
    output en, dir, mode, load, load_val, limit, step, prescale, clr_flags,
    input  count, dir_eff, tc, ovf_sticky, at_max, at_min, running
  );

  modport slave (
    input  en, dir, mode, load, load_val, limit, step, prescale, clr_flags,
    output count, dir_eff, tc, ovf_sticky, at_max, at_min, running
  );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: emits a tick every prescale_i+1 enabled cycles.
module tick_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  clr_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/updown_counter_gen.sv
// Up/down counter with programmable limit, step, prescaler and four boundary modes.
module updown_counter_gen import updown_pkg::*; #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned STEP_W     = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input logic                clk,
  input logic                rst,
  updown_counter_gen_if.slave bus
);

  // One spare bit so count+step never truncates before the limit compare.
  localparam int unsigned AW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_eff_q, dir_eff_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             running_q, running_d;

  logic             tick;
  logic             up;
  logic             bnd;
  logic [AW-1:0]    cnt_x, lim_x, step_x, sum_x, diff_x;

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .en_i       (bus.en & running_q),
    .clr_i      (bus.load),
    .prescale_i (bus.prescale),
    .tick_o     (tick)
  );

  assign cnt_x  = AW'(count_q);
  assign lim_x  = AW'(bus.limit);
  assign step_x = AW'(bus.step);
  assign sum_x  = cnt_x + step_x;
  assign diff_x = cnt_x - step_x;

  // Bounce mode keeps its own direction; the other modes use the live request.
  assign up = (bus.mode == MODE_BOUNCE) ? dir_eff_q : bus.dir;

  always_comb begin
    count_d   = count_q;
    dir_eff_d = (bus.mode == MODE_BOUNCE) ? dir_eff_q : bus.dir;
    running_d = running_q;
    bnd       = 1'b0;

    if (bus.load) begin
      count_d   = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      dir_eff_d = bus.dir;
      running_d = 1'b1;
    end else if (tick && (step_x != '0)) begin
      if (up == DIR_UP) begin
        if (sum_x <= lim_x) begin
          count_d = WIDTH'(sum_x);
        end else begin
          bnd = 1'b1;
        end
      end else begin
        if (cnt_x >= step_x) begin
          count_d = WIDTH'(diff_x);
        end else begin
          bnd = 1'b1;
        end
      end

      if (bnd) begin
        case (bus.mode)
          MODE_WRAP: count_d = up ? '0 : bus.limit;
          MODE_SAT:  count_d = up ? bus.limit : '0;
          MODE_BOUNCE: begin
            count_d   = up ? bus.limit : '0;
            dir_eff_d = ~up;
          end
          MODE_ONESHOT: begin
            count_d   = up ? bus.limit : '0;
            running_d = 1'b0;
          end
          default: count_d = count_q;
        endcase
      end
    end

    tc_d  = bnd;
    ovf_d = bnd | (ovf_q & ~bus.clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      dir_eff_q <= DIR_UP;
      tc_q      <= 1'b0;
      ovf_q     <= 1'b0;
      running_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      dir_eff_q <= dir_eff_d;
      tc_q      <= tc_d;
      ovf_q     <= ovf_d;
      running_q <= running_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.dir_eff    = dir_eff_q;
  assign bus.tc         = tc_q;
  assign bus.ovf_sticky = ovf_q;
  assign bus.running    = running_q;
  assign bus.at_max     = (count_q == bus.limit);
  assign bus.at_min     = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_gen.sv
// Scoreboard bench: a behavioural model queues expected state each edge, scenarios pop and compare.
module tb_updown_counter_gen;
  import updown_pkg::*;

  localparam int W  = 8;
  localparam int SW = 4;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  updown_counter_gen_if #(.WIDTH(W), .STEP_W(SW), .PRESCALE_W(PW)) u ();

  updown_counter_gen #(.WIDTH(W), .STEP_W(SW), .PRESCALE_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int count;
    bit tc;
    bit ovf;
    bit run;
    bit dir;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int m_count, m_pre;
  bit m_dir, m_ovf, m_run;

  // Reference model, evaluated on the pre-edge inputs.
  always @(posedge clk or posedge rst) begin : model
    exp_t n;
    int c, lim, st, pre;
    bit tk, d, ev;
    if (rst) begin
      m_count <= 0; m_pre <= 0; m_dir <= 1'b1; m_ovf <= 1'b0; m_run <= 1'b1;
      sb.delete();
    end else begin
      c = m_count; lim = int'(u.limit); st = int'(u.step); pre = m_pre; ev = 1'b0;
      n.count = c; n.run = m_run;
      n.dir = (u.mode == MODE_BOUNCE) ? m_dir : u.dir;
      if (u.load) begin
        n.count = (int'(u.load_val) < lim) ? int'(u.load_val) : lim;
        n.dir = u.dir; n.run = 1'b1; pre = 0;
      end else if (u.en && m_run) begin
        tk = (m_pre == int'(u.prescale));
        pre = tk ? 0 : (m_pre + 1) % 256;
        if (tk && st > 0) begin
          d = (u.mode == MODE_BOUNCE) ? m_dir : u.dir;
          if (d) begin
            if (c + st <= lim) n.count = c + st;
            else begin ev = 1'b1; n.count = (u.mode == MODE_WRAP) ? 0 : lim; end
          end else begin
            if (c - st >= 0) n.count = c - st;
            else begin ev = 1'b1; n.count = (u.mode == MODE_WRAP) ? lim : 0; end
          end
          if (ev && u.mode == MODE_BOUNCE) n.dir = !d;
          if (ev && u.mode == MODE_ONESHOT) n.run = 1'b0;
        end
      end
      n.tc = ev;
      n.ovf = ev || (m_ovf && !u.clr_flags);
      m_count <= n.count; m_pre <= pre; m_dir <= n.dir; m_ovf <= n.ovf; m_run <= n.run;
      sb.push_back(n);
    end
  end

  function automatic string got_s();
    return $sformatf("cnt=%0d tc=%b ovf=%b run=%b dir=%b max=%b min=%b", u.count, u.tc,
                     u.ovf_sticky, u.running, u.dir_eff, u.at_max, u.at_min);
  endfunction

  function automatic string exp_s(input exp_t x);
    return $sformatf("cnt=%0d tc=%b ovf=%b run=%b dir=%b", x.count, x.tc, x.ovf, x.run, x.dir);
  endfunction

  task automatic test_reset();
    #12;
    checks++;
    if (u.count !== 8'd0 || u.dir_eff !== 1'b1 || u.tc !== 1'b0 || u.ovf_sticky !== 1'b0 ||
        u.running !== 1'b1 || u.at_min !== 1'b1) begin
      errors++; $display("FAIL reset got %s required cnt=0 tc=0 ovf=0 run=1 dir=1 min=1", got_s());
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL wrap sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir || u.at_max !== (e.count == 9) ||
            u.at_min !== (e.count == 0)) begin
          errors++; $display("FAIL wrap[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      checks++;
      if (u.count !== 8'(i % 10) || u.tc !== (i == 10)) begin
        errors++; $display("FAIL wrap_seq[%0d] got cnt=%0d tc=%b required cnt=%0d tc=%b",
                           i, u.count, u.tc, i % 10, i == 10);
      end
    end
    checks++;
    if (u.ovf_sticky !== 1'b1) begin
      errors++; $display("FAIL wrap_ovf got %b required 1", u.ovf_sticky);
    end
  endtask

  task automatic test_saturate();
    int cnt_e[6] = '{195, 200, 200, 200, 3, 0};
    bit tc_e[6]  = '{0, 1, 1, 1, 0, 1};
    u.mode = MODE_SAT; u.limit = 8'd200; u.step = 4'd7; u.load_val = 8'd195;
    u.dir = 1'b1; u.load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL sat sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL sat[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      checks++;
      if (u.count !== 8'(cnt_e[i]) || u.tc !== tc_e[i]) begin
        errors++; $display("FAIL sat_seq[%0d] got cnt=%0d tc=%b required cnt=%0d tc=%b",
                           i, u.count, u.tc, cnt_e[i], tc_e[i]);
      end
      u.load = 1'b0;
      if (i == 3) begin u.load_val = 8'd3; u.dir = 1'b0; u.load = 1'b1; end
    end
  endtask

  task automatic test_bounce();
    int cnt_e[8] = '{0, 2, 4, 5, 3, 1, 0, 2};
    bit dir_e[8] = '{1, 1, 1, 0, 0, 0, 1, 1};
    bit tc_e[8]  = '{0, 0, 0, 1, 0, 0, 1, 0};
    u.mode = MODE_BOUNCE; u.limit = 8'd5; u.step = 4'd2; u.load_val = 8'd0;
    u.dir = 1'b1; u.load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL bounce sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL bounce[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      checks++;
      if (u.count !== 8'(cnt_e[i]) || u.dir_eff !== dir_e[i] || u.tc !== tc_e[i]) begin
        errors++; $display("FAIL bounce_seq[%0d] got %s required cnt=%0d dir=%b tc=%b",
                           i, got_s(), cnt_e[i], dir_e[i], tc_e[i]);
      end
      u.load = 1'b0;
    end
  endtask

  task automatic test_oneshot();
    int ce;
    u.mode = MODE_ONESHOT; u.limit = 8'd3; u.step = 4'd1; u.prescale = 8'd2;
    u.load_val = 8'd0; u.dir = 1'b1; u.load = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL oneshot sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL oneshot[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      ce = (i / 3 > 3) ? 3 : i / 3;
      checks++;
      if (u.count !== 8'(ce) || u.tc !== (i == 12) || u.running !== (i < 12 || i == 16)) begin
        errors++; $display("FAIL oneshot_seq[%0d] got %s required cnt=%0d tc=%b run=%b",
                           i, got_s(), ce, i == 12, i < 12 || i == 16);
      end
      u.load = 1'b0;
      if (i == 15) begin u.load_val = 8'd10; u.load = 1'b1; end
    end
    u.prescale = 8'd0;
  endtask

  task automatic test_load_priority();
    bit ld[5]    = '{1, 1, 1, 0, 0};
    int lv[5]    = '{9, 4, 9, 0, 0};
    bit clr[5]   = '{0, 0, 0, 1, 1};
    int cnt_e[5] = '{9, 4, 9, 0, 1};
    bit tc_e[5]  = '{0, 0, 0, 1, 0};
    bit ovf_e[5] = '{1, 1, 1, 1, 0};
    u.mode = MODE_WRAP; u.limit = 8'd9; u.step = 4'd1; u.dir = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u.load = ld[i]; u.load_val = 8'(lv[i]); u.clr_flags = clr[i];
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL loadpri sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL loadpri[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      checks++;
      if (u.count !== 8'(cnt_e[i]) || u.tc !== tc_e[i] || u.ovf_sticky !== ovf_e[i]) begin
        errors++; $display("FAIL loadpri_seq[%0d] got %s required cnt=%0d tc=%b ovf=%b",
                           i, got_s(), cnt_e[i], tc_e[i], ovf_e[i]);
      end
    end
    u.load = 1'b0; u.clr_flags = 1'b0;
  endtask

  task automatic test_async_reset_step0();
    u.mode = MODE_WRAP; u.limit = 8'd20; u.step = 4'd1; u.dir = 1'b1;
    u.load_val = 8'd0; u.load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL run7 sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL run7[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      u.load = 1'b0;
    end
    checks++;
    if (u.count !== 8'd7) begin
      errors++; $display("FAIL pre_rst_count got %0d required 7", u.count);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (u.count !== 8'd0 || u.ovf_sticky !== 1'b0 || u.running !== 1'b1 || u.tc !== 1'b0 ||
        u.dir_eff !== 1'b1) begin
      errors++; $display("FAIL async_rst got %s required cnt=0 tc=0 ovf=0 run=1 dir=1", got_s());
    end
    u.step = 4'd0; u.load_val = 8'd7; u.load = 1'b1;
    #1 rst = 1'b0;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) begin errors++; $display("FAIL step0 sb empty got %s", got_s()); end
      else begin
        e = sb.pop_front(); checks++;
        if (u.count !== 8'(e.count) || u.tc !== e.tc || u.ovf_sticky !== e.ovf ||
            u.running !== e.run || u.dir_eff !== e.dir) begin
          errors++; $display("FAIL step0[%0d] got %s required %s", i, got_s(), exp_s(e));
        end
      end
      checks++;
      if (u.count !== 8'd7 || u.tc !== 1'b0) begin
        errors++; $display("FAIL step0_seq[%0d] got cnt=%0d tc=%b required cnt=7 tc=0",
                           i, u.count, u.tc);
      end
      u.load = 1'b0;
    end
  endtask

  initial begin
    u.en = 1'b1; u.dir = 1'b1; u.mode = MODE_WRAP; u.load = 1'b0; u.load_val = 8'd0;
    u.limit = 8'd9; u.step = 4'd1; u.prescale = 8'd0; u.clr_flags = 1'b0;
    test_reset();
    test_wrap();
    test_saturate();
    test_bounce();
    test_oneshot();
    test_load_priority();
    test_async_reset_step0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/updown_counter_gen.md
Name: updown_counter_gen

Overview:
Parametrised successor to the fixed 8-bit up/down counter tile. Adds programmable upper limit, step size, tick prescaler, four boundary modes (wrap, saturate, bounce, one-shot), synchronous load and sticky overflow flag. Intended as the core of the next counter tile, driven from ui_in/uio_in decode logic, with count exported on uo_out.

Parameters:
WIDTH, 8, counter and limit width in bits (>=2)
STEP_W, 4, width of step input
PRESCALE_W, 8, width of prescaler reload value

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; 0 freezes count and prescaler
dir  in  1  requested direction, 1=up, 0=down
mode  in  2  00 wrap, 01 saturate, 10 bounce, 11 one-shot
load  in  1  synchronous load strobe
load_val  in  WIDTH  value loaded on load
limit  in  WIDTH  inclusive upper bound (lower bound fixed at 0)
step  in  STEP_W  increment per tick, zero-extended
prescale  in  PRESCALE_W  tick every prescale+1 enabled cycles
clr_flags  in  1  clears ovf_sticky
count  out  WIDTH  current count (registered)
dir_eff  out  1  effective direction (registered)
tc  out  1  one-cycle pulse on boundary event (registered)
ovf_sticky  out  1  set on any boundary event (registered)
at_max  out  1  count == limit (combinational from registers)
at_min  out  1  count == 0
running  out  1  0 when one-shot has halted (registered)

Behaviour:
- Reset (async, rst=1): count=0, dir_eff=1, prescaler=0, tc=0, ovf_sticky=0, running=1.
- Prescaler: increments on cycles with en=1 and running=1; tick asserted when prescaler==prescale, prescaler returns to 0 in same cycle. prescale=0 gives a tick every enabled cycle. en=0 holds prescaler value.
- Count updates on the clock edge of the tick cycle (1-cycle latency from tick to new count visible).
- Arithmetic in WIDTH+1 bits, no truncation before compare.
- Up tick: sum=count+step. sum<=limit -> count=sum. sum>limit, or count>limit already (limit lowered) -> boundary event.
- Down tick: count>=step -> count=count-step; else boundary event.
- Boundary event, up: wrap->0; saturate->limit; bounce->limit and dir_eff flips to 0; one-shot->limit, running=0.
- Boundary event, down: wrap->limit; saturate->0; bounce->0 and dir_eff flips to 1; one-shot->0, running=0.
- Saturate at limit and ticking up: each tick is a boundary event (tc pulses each tick).
- step=0: tick leaves count unchanged, no boundary event, no tc.
- dir_eff: modes 00/01/11 follow dir every cycle (registered); mode 10 changes only on load, reset or bounce flip.
- tc=1 for exactly the cycle after the boundary-event edge; otherwise 0.
- ovf_sticky: set on boundary event; clr_flags clears; set wins when simultaneous.
- load (priority over tick, independent of en): count=min(load_val, limit), prescaler=0, running=1, dir_eff=dir, no tc.
- One-shot halted (running=0): ticks ignored until load or rst.
- Mode change mid-count: takes effect at next tick; count not altered.
- rst asserted mid-operation: all state returns to reset values immediately, independent of clk.

Decomposition:
- Package updown_pkg: mode enum typedef (MODE_WRAP, MODE_SAT, MODE_BOUNCE, MODE_ONESHOT), direction constants DIR_UP/DIR_DOWN.
- Sub-module tick_prescaler (PRESCALE_W): clk, rst, en, clr, prescale -> tick. Core next-state logic stays in updown_counter_gen.

Test Plan:
- Reset, en=1, dir=1, mode=wrap, limit=9, step=1, prescale=0: count 0..9 then 0; tc high the cycle count becomes 0; ovf_sticky=1.
- mode=saturate, limit=200, step=7, load_val=195, dir=1: count 195 -> 200 (event) -> stays 200, tc pulses every tick; dir=0 from 3, step=7: 3 -> 0 with tc.
- mode=bounce, limit=5, step=2, from 0: 0,2,4,5(flip),3,1,0(flip),2; dir_eff toggles at 5 and 0.
- mode=one-shot, limit=3, step=1, prescale=2: count changes every 3rd cycle to 3, then running=0, holds; load load_val=10 -> count=3, running=1.
- Simultaneous load and tick, and clr_flags with boundary event: load value wins, no tc; ovf_sticky remains 1.
- rst asserted between clk edges at count=7: count=0, ovf_sticky=0, running=1 before next edge; step=0 for 10 ticks: count unchanged, tc never high.
